// File: rtl/yutorina_uart_tx.sv
// yutorina_uart_tx: buffered UART transmitter, 8N1 frames LSB first, with an optional even-parity bit.
// Latency: a byte written into an empty, idle block is popped on the next edge, and its start bit drives tx from that edge.
// Backpressure: wr_rdy is low while the FIFO holds FIFO_DEPTH bytes; a write then is dropped, even if a pop happens in the same cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wr_en, wr_data    byte write into the TX FIFO (accepted when wr_en & wr_rdy)
//   wr_rdy            FIFO not full
//   div_we, div_in    load the cycles-per-bit register
//   tx                serial line, idle high
//   busy              a frame is on the line
//   fifo_cnt          bytes currently held in the FIFO
//   irq               one-cycle pulse when the line goes idle with the FIFO empty
// Build option: define YUTORINA_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module yutorina_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 5,
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 87
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             wr_rdy,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_in,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             irq
);

  localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]   DIV_RST  = DIV_W'(DIV_DEFAULT);

`ifdef YUTORINA_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------- TX FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  assign wr_rdy   = (cnt != FULL_CNT);
  assign push     = wr_en && wr_rdy;
  assign fifo_cnt = cnt;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
    end
  end

  // ---------------- divisor register ----------------
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_eff;

  // A programmed divisor of 0 is treated as 1 so the bit timer always terminates.
  assign div_eff = (div_reg == '0) ? DIV_ONE : div_reg;

  always_ff @(posedge clk) begin
    if (rst)         div_reg <= DIV_RST;
    else if (div_we) div_reg <= div_in;
  end

  // ---------------- transmit FSM ----------------
  state_t           state;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] tmr;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             bit_end;
`ifdef YUTORINA_UART_TX_PARITY_EN
  logic             par;
`endif

  assign bit_end = (tmr == div_lat - DIV_ONE);

  // The head byte leaves the FIFO either from IDLE or at the end of a stop bit,
  // so consecutive frames run with no idle gap.
  assign pop = (cnt != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      irq     <= 1'b0;
      tmr     <= '0;
      div_lat <= DIV_ONE;
      shift   <= '0;
      bit_idx <= '0;
`ifdef YUTORINA_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      irq <= 1'b0;
      tmr <= ((state == IDLE) || bit_end) ? '0 : tmr + DIV_ONE;

      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef YUTORINA_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef YUTORINA_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end && !pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            irq   <= 1'b1;
            tx    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Frame start: overrides the per-state assignments above. The divisor is
      // latched here so later divisor writes only affect later frames.
      if (pop) begin
        state   <= START;
        tx      <= 1'b0;
        busy    <= 1'b1;
        shift   <= head;
        div_lat <= div_eff;
`ifdef YUTORINA_UART_TX_PARITY_EN
        par     <= ^head;
`endif
      end
    end
  end

endmodule

// File: tb/tb_yutorina_uart_tx.sv
// tb_yutorina_uart_tx: directed self-checking bench for yutorina_uart_tx.
// Inputs are driven and outputs sampled on the falling clock edge.
// Frame shapes are built from the byte value; parity frames when YUTORINA_UART_TX_PARITY_EN is defined.
module tb_yutorina_uart_tx;

  localparam int DIV_W = 16;
  localparam int CNT_W = 5;
`ifdef YUTORINA_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_rdy;
  logic             div_we = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_cnt;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;

  // serial monitor state (used by the FIFO-full scenario)
  logic       mon_en = 1'b0;
  int         mon_div = 8;
  int         rx_err = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  yutorina_uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .div_we   (div_we),
    .div_in   (div_in),
    .tx       (tx),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .irq      (irq)
  );

  // bit 0 = start, bits 1..8 = data LSB first, then parity (optional), then stop
  function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef YUTORINA_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [1023:0] expand(input logic [10:0] fr, input int div, input int nb);
    logic [1023:0] v = '0;
    for (int k = 0; k < div * nb; k++) v[k] = fr[k / div];
    return v;
  endfunction

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 1024; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // Samples tx at the current falling edge and the next n-1; returns on the n-th following falling edge.
  task automatic capture(input int n, output logic [1023:0] v, output int irq_n, output int busy_lo);
    v = '0; irq_n = 0; busy_lo = 0;
    for (int k = 0; k < n; k++) begin
      v[k] = tx;
      if (irq === 1'b1) irq_n++;
      if (busy !== 1'b1) busy_lo++;
      @(negedge clk);
    end
  endtask

  task automatic set_div(input logic [DIV_W-1:0] d);
    div_we = 1'b1; div_in = d;
    @(negedge clk);
    div_we = 1'b0;
  endtask

  // Frame decoder: samples each bit in its middle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin : rx_frame
        int d, off, tgt;
        logic [7:0] b;
        d = mon_div; off = 0; b = '0;
        for (int j = 0; j < 8; j++) begin
          tgt = d * (1 + j) + d / 2;
          repeat (tgt - off) @(negedge clk);
          off = tgt;
          b[j] = tx;
        end
        tgt = d * (FB - 1) + d / 2;
        repeat (tgt - off) @(negedge clk);
        if (tx !== 1'b1) rx_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %b want 1", wr_rdy); end
    n_tests++; if (fifo_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [1023:0] got, exp;
    int irq_n, busy_lo;
    set_div(16'd4);
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    n_tests++; if (fifo_cnt !== 5'd1) begin n_fail++; $display("FAIL single_cnt_push: got %0d want 1", fifo_cnt); end
    n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_pre_pop: tx=%b busy=%b want 1/0", tx, busy); end
    @(negedge clk);
    n_tests++; if (fifo_cnt !== 5'd0) begin n_fail++; $display("FAIL single_cnt_pop: got %0d want 0", fifo_cnt); end
    capture(FB * 4, got, irq_n, busy_lo);
    exp = expand(mk_frame(8'h55), 4, FB);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL single_wave: first bad cycle %0d got %b want %b", first_diff(got, exp), got[first_diff(got, exp)], exp[first_diff(got, exp)]); end
    n_tests++; if (irq_n != 0 || busy_lo != 0) begin n_fail++; $display("FAIL single_in_frame: irq pulses %0d busy-low cycles %0d want 0/0", irq_n, busy_lo); end
    n_tests++; if (irq !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL single_end: irq=%b busy=%b tx=%b want 1/0/1", irq, busy, tx); end
    @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_width: got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] got, exp;
    int irq_n, busy_lo;
    set_div(16'd2);
    wr_en = 1'b1; wr_data = 8'hA3;
    @(negedge clk);
    wr_data = 8'h0F;
    @(negedge clk);
    wr_en = 1'b0;
    n_tests++; if (fifo_cnt !== 5'd1) begin n_fail++; $display("FAIL b2b_cnt_push_pop: got %0d want 1", fifo_cnt); end
    capture(2 * FB * 2, got, irq_n, busy_lo);
    exp = expand(mk_frame(8'hA3), 2, FB) | (expand(mk_frame(8'h0F), 2, FB) << (FB * 2));
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL b2b_wave: first bad cycle %0d got %b want %b", first_diff(got, exp), got[first_diff(got, exp)], exp[first_diff(got, exp)]); end
    n_tests++; if (got[FB*2] !== 1'b0 || got[FB*2-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: stop=%b next=%b want 1/0", got[FB*2-1], got[FB*2]); end
    n_tests++; if (irq_n != 0 || busy_lo != 0) begin n_fail++; $display("FAIL b2b_in_frames: irq pulses %0d busy-low cycles %0d want 0/0", irq_n, busy_lo); end
    n_tests++; if (irq !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: irq=%b busy=%b want 1/0", irq, busy); end
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    int t;
    set_div(16'd8);
    mon_div = 8; rx_q.delete(); rx_err = 0; mon_en = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wr_data = 8'(i);
      @(negedge clk);
      if (i == 15) begin
        n_tests++; if (wr_rdy !== 1'b1 || fifo_cnt !== 5'd15) begin n_fail++; $display("FAIL full_at15: wr_rdy=%b cnt=%0d want 1/15", wr_rdy, fifo_cnt); end
      end
      if (i == 16) begin
        n_tests++; if (wr_rdy !== 1'b0 || fifo_cnt !== 5'd16) begin n_fail++; $display("FAIL full_at16: wr_rdy=%b cnt=%0d want 0/16", wr_rdy, fifo_cnt); end
      end
    end
    wr_en = 1'b0;
    n_tests++; if (fifo_cnt !== 5'd16) begin n_fail++; $display("FAIL full_drop: cnt=%0d want 16", fifo_cnt); end
    t = 0;
    while (rx_q.size() < 17 && t < 17 * FB * 8 + 200) begin @(negedge clk); t++; end
    repeat (40) @(negedge clk);
    n_tests++; if (rx_q.size() != 17) begin n_fail++; $display("FAIL full_count: received %0d bytes want 17", rx_q.size()); end
    for (int i = 0; i < 17; i++) begin
      if (i < rx_q.size()) begin
        n_tests++; if (rx_q[i] !== 8'(i)) begin n_fail++; $display("FAIL full_byte%0d: got %h want %h", i, rx_q[i], 8'(i)); end
      end
    end
    n_tests++; if (rx_err != 0) begin n_fail++; $display("FAIL full_stop_bits: %0d bad stop bits want 0", rx_err); end
    n_tests++; if (fifo_cnt !== 5'd0 || busy !== 1'b0 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL full_drain: cnt=%0d busy=%b wr_rdy=%b want 0/0/1", fifo_cnt, busy, wr_rdy); end
    mon_en = 1'b0;
  endtask

  task automatic test_div_change();
    logic [1023:0] got, exp;
    int irq_n, busy_lo;
    set_div(16'd4);
    wr_en = 1'b1; wr_data = 8'hFF;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    fork
      capture(FB * 4 + FB * 8, got, irq_n, busy_lo);
      begin
        repeat (10) @(negedge clk);
        div_we = 1'b1; div_in = 16'd8;
        @(negedge clk);
        div_we = 1'b0;
      end
    join
    exp = expand(mk_frame(8'hFF), 4, FB) | (expand(mk_frame(8'h3C), 8, FB) << (FB * 4));
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL div_change_wave: first bad cycle %0d got %b want %b", first_diff(got, exp), got[first_diff(got, exp)], exp[first_diff(got, exp)]); end
    n_tests++; if (irq !== 1'b1 || irq_n != 0) begin n_fail++; $display("FAIL div_change_irq: irq=%b early pulses %0d want 1/0", irq, irq_n); end
    set_div(16'd0);
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    capture(FB, got, irq_n, busy_lo);
    exp = expand(mk_frame(8'hA5), 1, FB);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL div_zero_wave: first bad cycle %0d got %b want %b", first_diff(got, exp), got[first_diff(got, exp)], exp[first_diff(got, exp)]); end
    n_tests++; if (irq !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL div_zero_end: irq=%b busy=%b want 1/0", irq, busy); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [1023:0] got, exp;
    int irq_n, busy_lo;
    set_div(16'd4);
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_tests++; if (fifo_cnt !== 5'd3) begin n_fail++; $display("FAIL rstmid_queued: cnt=%0d want 3", fifo_cnt); end
    repeat (15) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (tx !== 1'b1 || fifo_cnt !== 5'd0 || busy !== 1'b0 || wr_rdy !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: tx=%b cnt=%0d busy=%b wr_rdy=%b irq=%b want 1/0/0/1/0", tx, fifo_cnt, busy, wr_rdy, irq);
    end
    capture(40, got, irq_n, busy_lo);
    exp = '0;
    for (int k = 0; k < 40; k++) exp[k] = 1'b1;
    n_tests++; if (got !== exp || irq_n != 0 || busy_lo != 40) begin n_fail++; $display("FAIL rstmid_quiet: idle-bad cycle %0d irq pulses %0d busy-low %0d want -1/0/40", first_diff(got, exp), irq_n, busy_lo); end
    wr_en = 1'b1; wr_data = 8'h01;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    capture(FB * 87, got, irq_n, busy_lo);
    exp = expand(mk_frame(8'h01), 87, FB);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rstmid_default_div: first bad cycle %0d got %b want %b", first_diff(got, exp), got[first_diff(got, exp)], exp[first_diff(got, exp)]); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_irq_end: got %b want 1", irq); end
    @(negedge clk);
  endtask

`ifdef YUTORINA_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [1023:0] got, exp;
    int irq_n, busy_lo;
    set_div(16'd2);
    wr_en = 1'b1; wr_data = 8'h07;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    capture(22, got, irq_n, busy_lo);
    exp = expand({1'b1, 1'b1, 8'h07, 1'b0}, 2, 11);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL parity_07_wave: first bad cycle %0d", first_diff(got, exp)); end
    n_tests++; if (got[18] !== 1'b1 || got[19] !== 1'b1) begin n_fail++; $display("FAIL parity_07_bit: got %b%b want 11", got[18], got[19]); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL parity_07_len: irq=%b at cycle 22 want 1", irq); end
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h03;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    capture(22, got, irq_n, busy_lo);
    n_tests++; if (got[18] !== 1'b0 || got[19] !== 1'b0) begin n_fail++; $display("FAIL parity_03_bit: got %b%b want 00", got[18], got[19]); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL parity_03_len: irq=%b at cycle 22 want 1", irq); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_div_change();
    test_reset_mid_frame();
`ifdef YUTORINA_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
